// File: rtl/color_pkg.sv
// Shared widths and state encoding for the colour cache reader and write-back packer.
package color_pkg;

  localparam int unsigned N_CH   = 3;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 16;
  localparam int unsigned MEM_W  = 32;
  localparam int unsigned CH_W   = 2;

  typedef enum logic [1:0] {
    FILL_HI,
    FILL_LO,
    DRAIN,
    DONE
  } pack_state_t;

  // Zero-extend a packed channel word to the memory data width.
  function automatic logic [MEM_W-1:0] zext_word(input logic [WORD_W-1:0] w);
    return {{(MEM_W - WORD_W){1'b0}}, w};
  endfunction

endpackage

// File: rtl/color_write_packer_wrap_counter.sv
// Falling-edge address counter that steps MIN..MAX and wraps back to MIN.
module wrap_counter #(
  parameter int unsigned       WIDTH = 16,
  parameter logic [WIDTH-1:0]  MIN   = '0,
  parameter logic [WIDTH-1:0]  MAX   = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q, q_d;

  // Next value: hold, or advance with an explicit compare against MAX (not overflow).
  always_comb begin
    q_d = q_q;
    if (en) begin
      q_d = (q_q == MAX) ? MIN : q_q + WIDTH'(1);
    end
  end

  // Counter register, synchronous reset to MIN on the falling edge.
  always_ff @(negedge clk) begin
    if (rst) begin
      q_q <= MIN;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/color_write_packer.sv
// Packs two consecutive bytes per channel into 16-bit words (high byte first)
// and drains ch0..ch2 as zero-extended 32-bit writes at wrapping addresses.
module color_write_packer
  import color_pkg::*;
#(
  parameter int unsigned        ADDR_W    = 16,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = '0,
  parameter logic [ADDR_W-1:0]  LAST_ADDR = '1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           px_valid,
  output logic                           px_ready,
  input  logic [0:N_CH-1][BYTE_W-1:0]    px_in,
  input  logic                           flush,
  input  logic                           mem_busy,
  output logic                           mem_we,
  output logic [ADDR_W-1:0]              mem_addr,
  output logic [MEM_W-1:0]               mem_do,
  output logic                           done
);

  pack_state_t                     state_q, state_d;
  logic [CH_W-1:0]                 ch_q, ch_d;
  logic [N_CH-1:0][WORD_W-1:0]     hold_q, hold_d;
  logic                            flush_pend_q, flush_pend_d;
  logic                            we_q, we_d;
  logic                            done_q, done_d;
  logic [MEM_W-1:0]                do_q, do_d;
  logic                            accept;
  logic                            wr_done;

  assign px_ready = ~rst & ((state_q == FILL_HI) | (state_q == FILL_LO));
  assign accept   = px_valid & px_ready;
  assign wr_done  = (state_q == DRAIN) & we_q & ~mem_busy;

  wrap_counter #(
    .WIDTH (ADDR_W),
    .MIN   (BASE_ADDR),
    .MAX   (LAST_ADDR)
  ) u_addr (
    .clk (clk),
    .rst (rst),
    .en  (wr_done),
    .q   (mem_addr)
  );

  // Next-state, holding-register and write-port logic.
  always_comb begin
    state_d      = state_q;
    ch_d         = ch_q;
    hold_d       = hold_q;
    flush_pend_d = flush_pend_q;
    we_d         = we_q;
    do_d         = do_q;
    done_d       = 1'b0;

    unique case (state_q)
      FILL_HI: begin
        if (accept) begin
          for (int unsigned c = 0; c < N_CH; c++) begin
            hold_d[c[CH_W-1:0]][WORD_W-1:BYTE_W] = px_in[c[CH_W-1:0]];
          end
          // A flush arriving with the first byte closes the pair early.
          if (flush) flush_pend_d = 1'b1;
          state_d = FILL_LO;
        end else if (flush) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end

      FILL_LO: begin
        if (accept || flush || flush_pend_q) begin
          for (int unsigned c = 0; c < N_CH; c++) begin
            hold_d[c[CH_W-1:0]][BYTE_W-1:0] = accept ? px_in[c[CH_W-1:0]] : '0;
          end
          flush_pend_d = flush_pend_q | flush;
          ch_d         = '0;
          we_d         = 1'b1;
          do_d         = zext_word(hold_d[0]);
          state_d      = DRAIN;
        end
      end

      DRAIN: begin
        if (flush) flush_pend_d = 1'b1;
        if (wr_done) begin
          if (ch_q == CH_W'(N_CH - 1)) begin
            we_d         = 1'b0;
            ch_d         = '0;
            flush_pend_d = 1'b0;
            if (flush_pend_q || flush) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              state_d = FILL_HI;
            end
          end else begin
            ch_d = ch_q + CH_W'(1);
            do_d = zext_word(hold_q[ch_q + CH_W'(1)]);
          end
        end
      end

      DONE: begin
        state_d = FILL_HI;
      end

      default: begin
        state_d = FILL_HI;
      end
    endcase
  end

  // State and output registers, synchronous reset on the falling edge.
  always_ff @(negedge clk) begin
    if (rst) begin
      state_q      <= FILL_HI;
      ch_q         <= '0;
      hold_q       <= '0;
      flush_pend_q <= 1'b0;
      we_q         <= 1'b0;
      do_q         <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ch_q         <= ch_d;
      hold_q       <= hold_d;
      flush_pend_q <= flush_pend_d;
      we_q         <= we_d;
      do_q         <= do_d;
      done_q       <= done_d;
    end
  end

  assign mem_we = we_q;
  assign mem_do = do_q;
  assign done   = done_q;

endmodule

// File: tb/tb_color_write_packer.sv
// Directed bench: two packer instances (offset base, small wrapping range) share stimulus.
module tb_color_write_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic            px_valid;
  logic            flush;
  logic            mem_busy;
  logic [0:2][7:0] px_in;

  logic            a_ready, a_we, a_done;
  logic [15:0]     a_addr;
  logic [31:0]     a_do;
  logic            b_ready, b_we, b_done;
  logic [15:0]     b_addr;
  logic [31:0]     b_do;

  color_write_packer #(
    .ADDR_W    (16),
    .BASE_ADDR (16'h0010)
  ) dut_a (
    .clk      (clk),
    .rst      (rst),
    .px_valid (px_valid),
    .px_ready (a_ready),
    .px_in    (px_in),
    .flush    (flush),
    .mem_busy (mem_busy),
    .mem_we   (a_we),
    .mem_addr (a_addr),
    .mem_do   (a_do),
    .done     (a_done)
  );

  color_write_packer #(
    .ADDR_W    (16),
    .BASE_ADDR (16'h0000),
    .LAST_ADDR (16'h0003)
  ) dut_b (
    .clk      (clk),
    .rst      (rst),
    .px_valid (px_valid),
    .px_ready (b_ready),
    .px_in    (px_in),
    .flush    (flush),
    .mem_busy (mem_busy),
    .mem_we   (b_we),
    .mem_addr (b_addr),
    .mem_do   (b_do),
    .done     (b_done)
  );

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         qa[$];
  wr_t         qb[$];
  wr_t         ent;
  logic [15:0] ea, eb;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          lo;

  logic        s_ready_a, s_we_a, s_done_a, s_ready_b, s_we_b, s_done_b;
  logic [15:0] s_addr_a, s_addr_b;
  logic [31:0] s_do_a;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] next_a(input logic [15:0] x);
    return (x == 16'hFFFF) ? 16'h0010 : x + 16'd1;
  endfunction

  function automatic logic [15:0] next_b(input logic [15:0] x);
    return (x == 16'h0003) ? 16'h0000 : x + 16'd1;
  endfunction

  task automatic push_word(input logic [15:0] w);
    qa.push_back('{addr: ea, data: {16'h0000, w}});
    qb.push_back('{addr: eb, data: {16'h0000, w}});
    ea = next_a(ea);
    eb = next_b(eb);
  endtask

  task automatic drive(input logic v, input logic [0:2][7:0] p, input logic f, input logic b);
    px_valid = v;
    px_in    = p;
    flush    = f;
    mem_busy = b;
  endtask

  // Sample mid-cycle (DUT updates on the falling edge); retire completed writes against the scoreboard.
  task automatic cyc();
    @(posedge clk);
    s_ready_a = a_ready; s_we_a = a_we; s_done_a = a_done; s_addr_a = a_addr; s_do_a = a_do;
    s_ready_b = b_ready; s_we_b = b_we; s_done_b = b_done; s_addr_b = b_addr;
    if (a_we && !mem_busy && !rst) begin
      chk("a_write_expected", 32'(qa.size() > 0), 32'd1);
      if (qa.size() > 0) begin
        ent = qa.pop_front();
        chk("a_wr_addr", 32'(a_addr), 32'(ent.addr));
        chk("a_wr_data", a_do, ent.data);
      end
    end
    if (b_we && !mem_busy && !rst) begin
      chk("b_write_expected", 32'(qb.size() > 0), 32'd1);
      if (qb.size() > 0) begin
        ent = qb.pop_front();
        chk("b_wr_addr", 32'(b_addr), 32'(ent.addr));
        chk("b_wr_data", b_do, ent.data);
      end
    end
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);
    ea = 16'h0010;
    eb = 16'h0000;
    @(negedge clk);
    #1;

    // Reset state
    cyc();
    chk("rst_ready", 32'(s_ready_a), 32'd0);
    chk("rst_we", 32'(s_we_a), 32'd0);
    chk("rst_addr_a", 32'(s_addr_a), 32'h10);
    chk("rst_addr_b", 32'(s_addr_b), 32'h0);
    chk("rst_do", s_do_a, 32'd0);
    chk("rst_done", 32'(s_done_a), 32'd0);
    rst = 1'b0;
    cyc();
    chk("post_rst_ready", 32'(s_ready_a), 32'd1);

    // Basic pair
    drive(1'b1, {8'h11, 8'h22, 8'h33}, 1'b0, 1'b0);
    cyc();
    chk("basic_ready_hi", 32'(s_ready_a), 32'd1);
    drive(1'b1, {8'h44, 8'h55, 8'h66}, 1'b0, 1'b0);
    push_word(16'h1144); push_word(16'h2255); push_word(16'h3366);
    cyc();
    chk("basic_ready_lo", 32'(s_ready_a), 32'd1);
    drive(1'b0, '0, 1'b0, 1'b0);
    lo = 0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (!s_ready_a) lo++;
      chk("basic_we_drain", 32'(s_we_a), 32'd1);
    end
    cyc();
    if (!s_ready_a) lo++;
    chk("basic_we_after", 32'(s_we_a), 32'd0);
    chk("basic_ready_low_cycles", 32'(lo), 32'd3);
    chk("basic_queue_empty", 32'(qa.size()), 32'd0);

    // Backpressure on ch1 (also wraps instance b: 3,0,1)
    drive(1'b1, {8'h11, 8'h22, 8'h33}, 1'b0, 1'b0);
    cyc();
    drive(1'b1, {8'h44, 8'h55, 8'h66}, 1'b0, 1'b0);
    push_word(16'h1144); push_word(16'h2255); push_word(16'h3366);
    cyc();
    drive(1'b0, '0, 1'b0, 1'b0);
    lo = 0;
    cyc();
    if (!s_ready_a) lo++;
    for (int i = 0; i < 3; i++) begin
      mem_busy = (i < 2);
      cyc();
      if (!s_ready_a) lo++;
      chk("bp_hold_addr", 32'(s_addr_a), 32'h14);
      chk("bp_hold_data", s_do_a, 32'h0000_2255);
      chk("bp_hold_we", 32'(s_we_a), 32'd1);
    end
    mem_busy = 1'b0;
    cyc();
    if (!s_ready_a) lo++;
    cyc();
    if (!s_ready_a) lo++;
    chk("bp_drain_cycles", 32'(lo), 32'd5);

    // Flush in FILL_LO: zero-filled low bytes, then done
    drive(1'b1, {8'hAA, 8'hBB, 8'hCC}, 1'b0, 1'b0);
    cyc();
    drive(1'b0, '0, 1'b1, 1'b0);
    push_word(16'hAA00); push_word(16'hBB00); push_word(16'hCC00);
    cyc();
    chk("flo_ready", 32'(s_ready_a), 32'd1);
    drive(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("flo_done_low", 32'(s_done_a), 32'd0);
    end
    cyc();
    chk("flo_done", 32'(s_done_a), 32'd1);
    chk("flo_done_b", 32'(s_done_b), 32'd1);
    chk("flo_ready_in_done", 32'(s_ready_a), 32'd0);
    chk("flo_we_in_done", 32'(s_we_a), 32'd0);
    cyc();
    chk("flo_done_clear", 32'(s_done_a), 32'd0);
    chk("flo_ready_back", 32'(s_ready_a), 32'd1);

    // Flush in FILL_HI: done next cycle, no writes
    drive(1'b0, '0, 1'b1, 1'b0);
    cyc();
    drive(1'b0, '0, 1'b0, 1'b0);
    cyc();
    chk("fhi_done", 32'(s_done_a), 32'd1);
    chk("fhi_we", 32'(s_we_a), 32'd0);
    chk("fhi_we_b", 32'(s_we_b), 32'd0);
    cyc();
    chk("fhi_done_clear", 32'(s_done_a), 32'd0);

    // Flush pulse during the ch1 write
    drive(1'b1, {8'h12, 8'h34, 8'h56}, 1'b0, 1'b0);
    cyc();
    drive(1'b1, {8'h78, 8'h9A, 8'hBC}, 1'b0, 1'b0);
    push_word(16'h1278); push_word(16'h349A); push_word(16'h56BC);
    cyc();
    drive(1'b0, '0, 1'b0, 1'b0);
    cyc();
    chk("fdr_ready_ch0", 32'(s_ready_a), 32'd0);
    flush = 1'b1;
    cyc();
    chk("fdr_ready_ch1", 32'(s_ready_a), 32'd0);
    flush = 1'b0;
    cyc();
    chk("fdr_ready_ch2", 32'(s_ready_a), 32'd0);
    cyc();
    chk("fdr_done", 32'(s_done_a), 32'd1);
    chk("fdr_ready_in_done", 32'(s_ready_a), 32'd0);
    cyc();
    chk("fdr_done_clear", 32'(s_done_a), 32'd0);
    chk("fdr_ready_back", 32'(s_ready_b), 32'd1);
    chk("fdr_queue_empty", 32'(qb.size()), 32'd0);

    // Reset after the ch0 write: remaining words discarded
    drive(1'b1, {8'h01, 8'h02, 8'h03}, 1'b0, 1'b0);
    cyc();
    drive(1'b1, {8'h04, 8'h05, 8'h06}, 1'b0, 1'b0);
    push_word(16'h0104); push_word(16'h0205); push_word(16'h0306);
    cyc();
    drive(1'b0, '0, 1'b0, 1'b0);
    cyc();
    rst = 1'b1;
    cyc();
    chk("rmid_ready_in_rst", 32'(s_ready_a), 32'd0);
    qa.delete();
    qb.delete();
    ea = 16'h0010;
    eb = 16'h0000;
    rst = 1'b0;
    cyc();
    chk("rmid_we", 32'(s_we_a), 32'd0);
    chk("rmid_addr_a", 32'(s_addr_a), 32'h10);
    chk("rmid_addr_b", 32'(s_addr_b), 32'h0);
    chk("rmid_ready", 32'(s_ready_a), 32'd1);
    drive(1'b1, {8'h21, 8'h31, 8'h41}, 1'b0, 1'b0);
    cyc();
    drive(1'b1, {8'h22, 8'h32, 8'h42}, 1'b0, 1'b0);
    push_word(16'h2122); push_word(16'h3132); push_word(16'h4142);
    cyc();
    drive(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc();
    chk("end_queue_a_empty", 32'(qa.size()), 32'd0);
    chk("end_queue_b_empty", 32'(qb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/color_write_packer.md
# color_write_packer

Write-back packer for the per-channel colour path: accepts one 8-bit result per channel (ch0, ch1, ch2) per handshake and packs two consecutive results per channel into a 16-bit word, high byte first. It then drains the three words, in order ch0, ch1, ch2, to the data-memory write port as 32-bit zero-extended writes at consecutive, wrapping addresses. It is the output-side counterpart of the 3×16-bit colour cache that feeds the filter datapath, and uses the same byte ordering so that a read-back reproduces the stream.

## Interface
- ADDR_W, 16: width of the memory word address.
- BASE_ADDR, 0: first write address; value after reset.
- LAST_ADDR, 2**ADDR_W-1: last write address; the next write after it goes to BASE_ADDR. Must be ≥ BASE_ADDR.
- clk  in  1  clock; all state updates on the falling edge, matching the memory subsystem.
- rst  in  1  reset, synchronous, active-high.
- px_valid  in  1  px_in holds a valid 3-channel sample.
- px_ready  out  1  packer can accept a sample this cycle.
- px_in  in  8 ×[0:2]  channel bytes; index 0 = ch0.
- flush  in  1  one-cycle request to write out any partial pair and signal completion.
- mem_busy  in  1  memory cannot accept the presented write; hold it.
- mem_we  out  1  write strobe, registered.
- mem_addr  out  ADDR_W  write word address, registered.
- mem_do  out  32  write data, {16'd0, word}, registered.
- done  out  1  one-cycle pulse: the flush has completed.

## Operation
- Holding registers: hold[0:2], 16 bits each. The first accepted byte goes to [15:8] and the second to [7:0].
- States:
  - FILL_HI: px_ready=1. Accept (px_valid && px_ready): load hold[c][15:8], go to FILL_LO.
  - FILL_LO: px_ready=1. Accept: load hold[c][7:0], go to DRAIN with ch=0.
  - DRAIN: px_ready=0. Present hold[ch] with mem_we=1.
    - A write completes on a clock edge where mem_we=1 and mem_busy=0.
    - On completion: mem_addr advances (LAST_ADDR→BASE_ADDR, else +1) and ch increments.
    - After the ch2 write completes: go to FILL_HI and drop mem_we, unless more work is pending.
  - DONE: one cycle with done=1, then FILL_HI.
- Flush rules:
  - Flush in FILL_HI (no accept the same cycle): go to DONE; no writes.
  - Flush in FILL_LO with no accept: hold[c][7:0] are zero-filled; go to DRAIN. After the ch2 write completes, go to DONE.
  - Flush in FILL_LO coinciding with an accept: the byte is taken, then DRAIN → DONE.
  - Flush during DRAIN: latched in flush_pend; after the ch2 write completes, go to DONE (not FILL_HI).
  - Flush in DONE: ignored.
- mem_busy is ignored outside DRAIN.
- mem_addr, mem_do and mem_we stay stable while mem_busy=1.
- Address arithmetic is unsigned ADDR_W bits; the wrap compare is against LAST_ADDR, not overflow.

## Timing
- While rst=1 and on the edge it is sampled:
  - state=FILL_HI, ch=0, flush_pend=0, hold=0
  - mem_we=0, mem_addr=BASE_ADDR, mem_do=0, done=0
  - px_ready forced 0 while rst=1.
- px_ready is combinational from state (and ~rst).
- Latency: the edge that accepts the second byte also registers mem_we=1 and mem_do={16'd0, ch0 word}. The ch0 write is visible in the following cycle.
- Throughput with mem_busy=0: 2 accept cycles + 3 write cycles = 5 cycles per pair.
- Each cycle of mem_busy=1 in DRAIN adds exactly one cycle.
- done asserts exactly one cycle after the final write completes, or one cycle after a flush in FILL_HI.
- Reset mid-DRAIN: pending words and flush_pend are discarded; mem_we=0 on the reset edge.

## Structure
- Package color_pkg: N_CH=3, BYTE_W=8, WORD_W=16, and typedef enum logic [1:0] {FILL_HI, FILL_LO, DRAIN, DONE} pack_state_t. The cache reader shares N_CH, BYTE_W and WORD_W.
- Sub-module wrap_counter (parameters WIDTH, MIN, MAX; ports clk, rst, en, q) for mem_addr. The ch index is a local 2-bit counter.
- Everything else stays in one module with a single falling-edge always_ff plus combinational next-state logic.

## Test plan
- Basic pair, BASE_ADDR=0x10:
  - Stimulus: accept {0x11,0x22,0x33} then {0x44,0x55,0x66}, mem_busy=0.
  - Required: writes 0x00001144@0x10, 0x00002255@0x11, 0x00003366@0x12 on three consecutive cycles; px_ready=0 for exactly those 3 cycles.
- Backpressure:
  - Stimulus: same input, mem_busy=1 for 2 cycles during the ch1 write.
  - Required: mem_addr=0x11 and mem_do=0x00002255 held for 3 cycles; total drain 5 cycles; no duplicate or skipped address.
- Wrap:
  - Stimulus: BASE_ADDR=0x0, LAST_ADDR=0x3, two pairs.
  - Required: write addresses 0,1,2,3,0,1.
- Flush:
  - Stimulus 1: flush in FILL_LO after {0xAA,0xBB,0xCC}. Required: writes 0xAA00, 0xBB00, 0xCC00, then done=1 one cycle later.
  - Stimulus 2: flush in FILL_HI. Required: done next cycle, no mem_we.
- Reset mid-DRAIN:
  - Stimulus: rst=1 after the ch0 write.
  - Required: mem_we=0, mem_addr=BASE_ADDR, px_ready=1 after release; the next pair writes at BASE_ADDR.
- Flush during DRAIN:
  - Stimulus: flush pulse during the ch1 write.
  - Required: ch2 write completes, done pulses the next cycle, px_ready stays 0 until done has been asserted.
